// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares the single-strobe CPU register bus between two
// requesters (0 = host AXI-Lite bridge, 1 = internal command/DMA engine).
// Each transaction runs IDLE -> STROBE -> RESP -> IDLE: one arbitration
// cycle, one bus strobe, then a held response until the requester takes it.
//
// Build option: define CPU_ARB_RR_EN for round-robin arbitration between
// simultaneous requesters; without it requester 0 has fixed priority.

module cpu_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    // requester 0 (host bridge)
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req0_rready,

    // requester 1 (internal engine)
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    input  logic              req1_rready,

    // register bus toward the address decode
    output logic              CPURead,
    output logic              CPUWrite,
    output logic [ADDR_W-1:0] CPUAddress,
    output logic [DATA_W-1:0] CPUWriteData,
    input  logic [DATA_W-1:0] CPUReadData,

    output logic              arb_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic   grant;      // requester owning the current transaction
    logic   lat_write;  // latched direction of the current transaction
    logic   any_valid;
    logic   win;        // arbitration result, meaningful only when any_valid
    logic   resp_ack;   // granted requester takes the response

`ifdef CPU_ARB_RR_EN
    logic   last_grant; // requester served by the most recent transaction
`endif

    assign any_valid = req0_valid | req1_valid;
    assign resp_ack  = grant ? req1_rready : req0_rready;

    // Pick the winner among the currently valid requesters.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        win = 1'b0;
`ifdef CPU_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            win = ~last_grant;
        end else begin
            win = ~req0_valid;  // a lone valid requester always wins
        end
`else
        win = ~req0_valid;      // requester 0 wins whenever it is valid
`endif
    end

    // Next-state decode for the transaction sequencer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = STROBE;
                end
            end
            STROBE: begin
                state_nxt = RESP;       // the strobe is exactly one cycle
            end
            RESP: begin
                if (resp_ack) begin
                    state_nxt = IDLE;   // new requests are ignored until here
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight transaction immediately.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus-side and handshake outputs, decoded from state and latched fields.
    always_comb begin
        // NOTE: these depend only on registered values, never on the request
        // inputs, so an asynchronous reset clears the strobes at once and no
        // requester-to-bus combinational path exists.
        CPURead     = 1'b0;
        CPUWrite    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        req0_rvalid = 1'b0;
        req1_rvalid = 1'b0;
        arb_busy    = (state != IDLE);
        if (state == STROBE) begin
            CPUWrite   = lat_write;
            CPURead    = ~lat_write;
            req0_ready = ~grant;
            req1_ready = grant;
        end
        if (state == RESP) begin
            req0_rvalid = ~grant;
            req1_rvalid = grant;
        end
    end

    // Latch the winner's payload in the arbitration cycle; the bus address
    // and write data then hold until the next transaction is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant        <= 1'b0;
            lat_write    <= 1'b0;
            CPUAddress   <= '0;
            CPUWriteData <= '0;
        end else if (state == IDLE && any_valid) begin
            grant        <= win;
            lat_write    <= win ? req1_write : req0_write;
            CPUAddress   <= win ? req1_addr  : req0_addr;
            CPUWriteData <= win ? req1_wdata : req0_wdata;
        end
    end

    // Capture the response for the granted requester at the end of STROBE;
    // the other requester's last response is left untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else if (state == STROBE) begin
            if (grant) begin
                req1_rdata <= lat_write ? '0 : CPUReadData;
            end else begin
                req0_rdata <= lat_write ? '0 : CPUReadData;
            end
        end
    end

`ifdef CPU_ARB_RR_EN
    // Remember who was served once its response handshake completes; the
    // reset value makes requester 0 win the first contested arbitration.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (state == RESP && resp_ack) begin
            last_grant <= grant;
        end
    end
`endif

endmodule
